// File: rtl/mem_access_stage_if.sv
// Memory-controller request/completion bus used by mem_access_stage.
// The stage (master) holds op/len/addr/data stable until the controller (slave)
// returns a one-cycle fin pulse with load data on out.
interface mem_access_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic [1:0]      op;    // 00 NOP, 01 LOAD, 10 SAVE
    logic [1:0]      len;   // 00 byte, 01 half, 10 word
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic            fin;
    logic [XLEN-1:0] out;

    modport master (
        output op,
        output len,
        output addr,
        output data,
        input  fin,
        input  out
    );

    modport slave (
        input  op,
        input  len,
        input  addr,
        input  data,
        output fin,
        output out
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage between EX and WB: issues RV32I loads/stores over a held
// request / fin handshake, extends load data, drives WB, forwarding and stall.
// Optional feature: define MEM_MISALIGN_CHECK_EN to trap misaligned half/word
// accesses (no request issued, one-cycle exc_misalign strobe).
`ifndef LOAD
`define LOAD 7'b0000011
`endif
`ifndef SAVE
`define SAVE 7'b0100011
`endif
`ifndef ADDI
`define ADDI 7'b0010011
`endif

module mem_access_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned TYPE_W = 7
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              in_valid,
    input  logic [TYPE_W-1:0] ins_type,
    input  logic [2:0]        ins_details,
    input  logic [REG_W-1:0]  rd_addr,
    input  logic [XLEN-1:0]   rd_val,
    input  logic              forward,
    input  logic [XLEN-1:0]   mem_addr,
    input  logic [XLEN-1:0]   mem_val,
    mem_access_stage_if.master memctl,
    output logic              stall,
    output logic              fwd_valid,
    output logic              fwd_pending,
    output logic [REG_W-1:0]  fwd_rd_addr,
    output logic [XLEN-1:0]   fwd_rd_val,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_rd_addr,
    output logic [XLEN-1:0]   wb_rd_val,
    output logic [TYPE_W-1:0] wb_ins_type,
    output logic              exc_misalign
);

    localparam logic [TYPE_W-1:0] TypeLoad = TYPE_W'(`LOAD);
    localparam logic [TYPE_W-1:0] TypeSave = TYPE_W'(`SAVE);
    localparam logic [TYPE_W-1:0] TypeAddi = TYPE_W'(`ADDI);

    localparam logic [1:0] OpNop  = 2'b00;
    localparam logic [1:0] OpLoad = 2'b01;
    localparam logic [1:0] OpSave = 2'b10;

    localparam logic [1:0] LenByte = 2'b00;
    localparam logic [1:0] LenHalf = 2'b01;
    localparam logic [1:0] LenWord = 2'b10;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [1:0]          len_q, len_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     data_q, data_d;
    logic                wb_valid_q, wb_valid_d;
    logic [REG_W-1:0]    wb_rd_addr_q, wb_rd_addr_d;
    logic [XLEN-1:0]     wb_rd_val_q, wb_rd_val_d;
    logic [TYPE_W-1:0]   wb_ins_type_q, wb_ins_type_d;
    logic                exc_q, exc_d;
    logic [2:0]          f3_q, f3_d;
    logic                is_load_q, is_load_d;

    logic                in_load, in_save, mem_op;
    logic [1:0]          req_len;
    logic                misalign;

    assign in_load = (ins_type == TypeLoad);
    assign in_save = (ins_type == TypeSave);
    assign mem_op  = in_valid & (in_load | in_save);
    // funct3[1:0]==11 is not a legal width; treat it as a word access
    assign req_len = (ins_details[1:0] == 2'b11) ? LenWord : ins_details[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign = ((req_len == LenHalf) & mem_addr[0]) |
                      ((req_len == LenWord) & (mem_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Sign/zero extension of returned load data by funct3
    function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        case (f3)
            3'b000:  r = {{(XLEN-8){d[7]}}, d[7:0]};
            3'b001:  r = {{(XLEN-16){d[15]}}, d[15:0]};
            3'b100:  r = {{(XLEN-8){1'b0}}, d[7:0]};
            3'b101:  r = {{(XLEN-16){1'b0}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Next-state, request, writeback and forwarding/stall logic
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        len_d         = len_q;
        addr_d        = addr_q;
        data_d        = data_q;
        wb_valid_d    = wb_valid_q;
        wb_rd_addr_d  = wb_rd_addr_q;
        wb_rd_val_d   = wb_rd_val_q;
        wb_ins_type_d = wb_ins_type_q;
        exc_d         = exc_q;
        f3_d          = f3_q;
        is_load_d     = is_load_q;
        stall         = 1'b0;
        fwd_valid     = 1'b0;
        fwd_pending   = 1'b0;
        fwd_rd_addr   = rd_addr;
        fwd_rd_val    = rd_val;

        case (state_q)
            StIdle: begin
                if (mem_op) begin
                    stall         = 1'b1;
                    fwd_pending   = in_load;
                    wb_valid_d    = 1'b0;
                    f3_d          = ins_details;
                    is_load_d     = in_load;
                    wb_ins_type_d = ins_type;
                    wb_rd_addr_d  = in_load ? rd_addr : '0;
                    if (misalign) begin
                        // Trap without touching the controller
                        wb_valid_d   = 1'b1;
                        wb_rd_addr_d = '0;
                        wb_rd_val_d  = '0;
                        exc_d        = 1'b1;
                        state_d      = StDone;
                    end else begin
                        op_d    = in_load ? OpLoad : OpSave;
                        len_d   = req_len;
                        addr_d  = mem_addr;
                        data_d  = mem_val;
                        state_d = StBusy;
                    end
                end else begin
                    wb_valid_d    = in_valid;
                    wb_rd_addr_d  = rd_addr;
                    wb_rd_val_d   = rd_val;
                    wb_ins_type_d = ins_type;
                    fwd_valid     = forward;
                end
            end
            StBusy: begin
                stall       = 1'b1;
                fwd_pending = is_load_q;
                if (memctl.fin) begin
                    op_d        = OpNop;
                    wb_rd_val_d = is_load_q ? extend(f3_q, memctl.out) : '0;
                    wb_valid_d  = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                wb_valid_d  = 1'b0;
                exc_d       = 1'b0;
                state_d     = StIdle;
                // Loaded value is already in the WB registers this cycle
                fwd_valid   = is_load_q & ~exc_q;
                fwd_rd_addr = wb_rd_addr_q;
                fwd_rd_val  = wb_rd_val_q;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers: synchronous reset, frozen while rdy_in is low
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= StIdle;
            op_q          <= OpNop;
            len_q         <= LenByte;
            addr_q        <= '0;
            data_q        <= '0;
            wb_valid_q    <= 1'b0;
            wb_rd_addr_q  <= '0;
            wb_rd_val_q   <= '0;
            wb_ins_type_q <= TypeAddi;
            exc_q         <= 1'b0;
            f3_q          <= 3'b000;
            is_load_q     <= 1'b0;
        end else if (rdy_in) begin
            state_q       <= state_d;
            op_q          <= op_d;
            len_q         <= len_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_addr_q  <= wb_rd_addr_d;
            wb_rd_val_q   <= wb_rd_val_d;
            wb_ins_type_q <= wb_ins_type_d;
            exc_q         <= exc_d;
            f3_q          <= f3_d;
            is_load_q     <= is_load_d;
        end
    end

    assign memctl.op    = op_q;
    assign memctl.len   = len_q;
    assign memctl.addr  = addr_q;
    assign memctl.data  = data_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd_addr   = wb_rd_addr_q;
    assign wb_rd_val    = wb_rd_val_q;
    assign wb_ins_type  = wb_ins_type_q;
    assign exc_misalign = exc_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus pushes expected WB retirements,
// a negedge monitor pops and compares on every wb_valid strobe.
module tb_mem_access_stage;

    localparam logic [6:0] T_LOAD = 7'b0000011;
    localparam logic [6:0] T_SAVE = 7'b0100011;
    localparam logic [6:0] T_ADDI = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst, rdy, in_valid, forward;
    logic [6:0]  ins_type;
    logic [2:0]  ins_details;
    logic [4:0]  rd_addr;
    logic [31:0] rd_val, mem_addr, mem_val;
    logic        stall, fwd_valid, fwd_pending, wb_valid, exc_misalign;
    logic [4:0]  fwd_rd_addr, wb_rd_addr;
    logic [31:0] fwd_rd_val, wb_rd_val;
    logic [6:0]  wb_ins_type;

    mem_access_stage_if #(.XLEN(32)) memctl ();

    mem_access_stage #(.XLEN(32), .REG_W(5), .TYPE_W(7)) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .rdy_in       (rdy),
        .in_valid     (in_valid),
        .ins_type     (ins_type),
        .ins_details  (ins_details),
        .rd_addr      (rd_addr),
        .rd_val       (rd_val),
        .forward      (forward),
        .mem_addr     (mem_addr),
        .mem_val      (mem_val),
        .memctl       (memctl),
        .stall        (stall),
        .fwd_valid    (fwd_valid),
        .fwd_pending  (fwd_pending),
        .fwd_rd_addr  (fwd_rd_addr),
        .fwd_rd_val   (fwd_rd_val),
        .wb_valid     (wb_valid),
        .wb_rd_addr   (wb_rd_addr),
        .wb_rd_val    (wb_rd_val),
        .wb_ins_type  (wb_ins_type),
        .exc_misalign (exc_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        logic [6:0]  ty;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] val, input logic [6:0] ty);
        exp_t e;
        e.rd  = rd;
        e.val = val;
        e.ty  = ty;
        sb.push_back(e);
    endtask

    // Monitor: every retirement must match the oldest expected entry
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_rd_addr", 32'(wb_rd_addr), 32'(e.rd));
                chk("wb_rd_val", wb_rd_val, e.val);
                chk("wb_ins_type", 32'(wb_ins_type), 32'(e.ty));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One memory instruction from IDLE through DONE, back to IDLE on exit
    task automatic do_mem(input string nm, input logic [6:0] ty, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] val,
                          input int busy, input logic [31:0] rdata,
                          input logic [1:0] exp_op, input logic [1:0] exp_len,
                          input logic [31:0] exp_res);
        logic ld;
        ld = (ty == T_LOAD);
        in_valid = 1'b1; ins_type = ty; ins_details = f3; rd_addr = rd;
        rd_val = 32'h0BAD_0BAD; forward = 1'b1; mem_addr = addr; mem_val = val;
        #1;
        chk({nm, "_idle_stall"}, 32'(stall), 32'd1);
        chk({nm, "_idle_fwd_valid"}, 32'(fwd_valid), 32'd0);
        chk({nm, "_idle_fwd_pending"}, 32'(fwd_pending), 32'(ld));
        tick();
        chk({nm, "_op"}, 32'(memctl.op), 32'(exp_op));
        chk({nm, "_len"}, 32'(memctl.len), 32'(exp_len));
        chk({nm, "_addr"}, memctl.addr, addr);
        if (!ld) chk({nm, "_data"}, memctl.data, val);
        for (int i = 1; i < busy; i++) begin
            tick();
            chk({nm, "_busy_stall"}, 32'(stall), 32'd1);
            chk({nm, "_busy_pending"}, 32'(fwd_pending), 32'(ld));
            chk({nm, "_busy_op_held"}, 32'(memctl.op), 32'(exp_op));
            if (!ld) chk({nm, "_busy_data_held"}, memctl.data, val);
        end
        memctl.fin = 1'b1; memctl.out = rdata;
        #1;
        chk({nm, "_fin_stall"}, 32'(stall), 32'd1);
        tick();
        memctl.fin = 1'b0;
        chk({nm, "_done_stall"}, 32'(stall), 32'd0);
        chk({nm, "_done_op"}, 32'(memctl.op), 32'd0);
        chk({nm, "_done_fwd_valid"}, 32'(fwd_valid), 32'(ld));
        if (ld) chk({nm, "_done_fwd_val"}, fwd_rd_val, exp_res);
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; in_valid = 1'b0; forward = 1'b0;
        ins_type = T_ADDI; ins_details = 3'b000; rd_addr = '0; rd_val = '0;
        mem_addr = '0; mem_val = '0; memctl.fin = 1'b0; memctl.out = '0;
        tick();
        tick();
        chk("rst_op", 32'(memctl.op), 32'd0);
        chk("rst_len", 32'(memctl.len), 32'd0);
        chk("rst_addr", memctl.addr, 32'd0);
        chk("rst_data", memctl.data, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd_addr", 32'(wb_rd_addr), 32'd0);
        chk("rst_wb_rd_val", wb_rd_val, 32'd0);
        chk("rst_wb_ins_type", 32'(wb_ins_type), 32'(T_ADDI));
        chk("rst_exc", 32'(exc_misalign), 32'd0);
        rst = 1'b0;

        // ADDI passes straight through in one cycle
        in_valid = 1'b1; ins_type = T_ADDI; rd_addr = 5'd3; rd_val = 32'h55; forward = 1'b1;
        #1;
        chk("addi_stall", 32'(stall), 32'd0);
        chk("addi_fwd_valid", 32'(fwd_valid), 32'd1);
        chk("addi_fwd_rd", 32'(fwd_rd_addr), 32'd3);
        chk("addi_fwd_val", fwd_rd_val, 32'h55);
        push(5'd3, 32'h55, T_ADDI);
        tick();
        forward = 1'b0; #1;
        chk("nofwd_fwd_valid", 32'(fwd_valid), 32'd0);
        in_valid = 1'b0;
        tick();

        push(5'd5, 32'hFFFF_FF80, T_LOAD);
        do_mem("lb", T_LOAD, 3'b000, 5'd5, 32'h100, 32'h0, 4, 32'h80, 2'b01, 2'b00, 32'hFFFF_FF80);
        push(5'd6, 32'h0000_8001, T_LOAD);
        do_mem("lhu", T_LOAD, 3'b101, 5'd6, 32'h202, 32'h0, 2, 32'h0001_8001, 2'b01, 2'b01,
               32'h0000_8001);
        push(5'd0, 32'h0, T_SAVE);
        do_mem("sw", T_SAVE, 3'b010, 5'd7, 32'h300, 32'hDEAD_BEEF, 3, 32'h0, 2'b10, 2'b10, 32'h0);
        push(5'd8, 32'hFFFF_F0F0, T_LOAD);
        do_mem("lh", T_LOAD, 3'b001, 5'd8, 32'h10, 32'h0, 1, 32'h0000_F0F0, 2'b01, 2'b01,
               32'hFFFF_F0F0);
        push(5'd11, 32'h0000_00A5, T_LOAD);
        do_mem("lbu", T_LOAD, 3'b100, 5'd11, 32'h13, 32'h0, 1, 32'h1234_56A5, 2'b01, 2'b00,
               32'h0000_00A5);
        push(5'd0, 32'hCAFE_BABE, T_LOAD);
        do_mem("lw_x0", T_LOAD, 3'b010, 5'd0, 32'h104, 32'h0, 2, 32'hCAFE_BABE, 2'b01, 2'b10,
               32'hCAFE_BABE);
        push(5'd12, 32'h0000_00FF, T_SAVE == 7'd0 ? T_ADDI : T_LOAD);
        do_mem("lbu_ff", T_LOAD, 3'b100, 5'd12, 32'h20, 32'h0, 1, 32'hFFFF_FFFF, 2'b01, 2'b00,
               32'h0000_00FF);

        // rdy low freezes BUSY even with fin pulsed
        push(5'd9, 32'h2222_2222, T_LOAD);
        in_valid = 1'b1; ins_type = T_LOAD; ins_details = 3'b010; rd_addr = 5'd9;
        mem_addr = 32'h400;
        tick();
        rdy = 1'b0; memctl.fin = 1'b1; memctl.out = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_op", 32'(memctl.op), 32'd1);
            chk("frz_stall", 32'(stall), 32'd1);
        end
        memctl.fin = 1'b0; rdy = 1'b1;
        tick();
        chk("frz_still_busy", 32'(memctl.op), 32'd1);
        memctl.fin = 1'b1; memctl.out = 32'h2222_2222;
        tick();
        memctl.fin = 1'b0;
        chk("frz_done_fwd", fwd_rd_val, 32'h2222_2222);
        in_valid = 1'b0;
        tick();

        // fin while idle is ignored
        memctl.fin = 1'b1;
        tick();
        memctl.fin = 1'b0;
        chk("idle_fin_op", 32'(memctl.op), 32'd0);

        // Reset during BUSY drops the request
        in_valid = 1'b1; ins_type = T_LOAD; ins_details = 3'b010; rd_addr = 5'd10;
        mem_addr = 32'h500;
        tick();
        chk("rstb_busy_op", 32'(memctl.op), 32'd1);
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("rstb_op", 32'(memctl.op), 32'd0);
        chk("rstb_wb_ins_type", 32'(wb_ins_type), 32'(T_ADDI));
        chk("rstb_stall", 32'(stall), 32'd0);
        tick();

`ifdef MEM_MISALIGN_CHECK_EN
        push(5'd0, 32'h0, T_LOAD);
        in_valid = 1'b1; ins_type = T_LOAD; ins_details = 3'b010; rd_addr = 5'd4;
        mem_addr = 32'h102;
        tick();
        in_valid = 1'b0;
        chk("mis_op", 32'(memctl.op), 32'd0);
        chk("mis_exc", 32'(exc_misalign), 32'd1);
        chk("mis_fwd_valid", 32'(fwd_valid), 32'd0);
        tick();
        chk("mis_exc_clr", 32'(exc_misalign), 32'd0);
        chk("mis_op_idle", 32'(memctl.op), 32'd0);
`else
        push(5'd4, 32'h0BAD_F00D, T_LOAD);
        do_mem("mis_pass", T_LOAD, 3'b010, 5'd4, 32'h102, 32'h0, 1, 32'h0BAD_F00D, 2'b01, 2'b10,
               32'h0BAD_F00D);
        chk("mis_exc_tied", 32'(exc_misalign), 32'd0);
`endif

        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
